// File: rtl/uart_tx_feeder_pkg.sv
// Shared types for the UART transmit feeder: byte width and feeder FSM states.
package uart_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY     = 2'd1,
      WAIT_LOW = 2'd2
   } feeder_state_t;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock FIFO with registered occupancy count, peek output and pop input.
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int DATA_W = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [DATA_W-1:0] peek_data,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              wr_acc;
   logic              pop_acc;

   // count is authoritative, so pointers simply wrap without an extra phase bit
   assign full      = (count == (AW+1)'(DEPTH));
   assign empty     = (count == '0);
   assign wr_acc    = wr_en && !full;
   assign pop_acc   = pop && !empty;
   assign peek_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop_acc) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + (AW+1)'(wr_acc) - (AW+1)'(pop_acc);
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer and launch controller feeding uart_tx one byte per completion.
// Optional almost_full output enabled by UART_TX_FEEDER_ALMOST_FULL_EN.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int DATA_W = uart_pkg::DATA_W,
`ifdef UART_TX_FEEDER_ALMOST_FULL_EN
   parameter int AF_LEVEL = DEPTH - 2,
`endif
   localparam int AW = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       count,
   output logic              overflow,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_start,
   input  logic              tx_done
`ifdef UART_TX_FEEDER_ALMOST_FULL_EN
   ,
   output logic              almost_full
`endif
);

   feeder_state_t     state;
   feeder_state_t     state_nxt;
   logic              tx_done_q;
   logic              done_rise;
   logic              launch;
   logic              pop;
   logic [DATA_W-1:0] peek_data;

   sync_fifo #(
      .DEPTH (DEPTH),
      .DATA_W(DATA_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .pop      (pop),
      .peek_data(peek_data),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

   assign done_rise = tx_done && !tx_done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (!empty)   state_nxt = BUSY;
         BUSY:     if (done_rise) state_nxt = WAIT_LOW;
         WAIT_LOW: if (!tx_done) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // The launched byte is only peeked; it leaves the FIFO on the completion rise.
   always_comb begin
      launch = 1'b0;
      pop    = 1'b0;
      case (state)
         IDLE:    launch = !empty;
         BUSY:    pop    = done_rise;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_done_q <= 1'b0;
         overflow  <= 1'b0;
         tx_start  <= 1'b0;
         tx_data   <= '0;
      end else begin
         tx_done_q <= tx_done;
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (launch) begin
            tx_start <= 1'b1;
            tx_data  <= peek_data;
         end else if (pop) begin
            tx_start <= 1'b0;
         end
      end
   end

`ifdef UART_TX_FEEDER_ALMOST_FULL_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         almost_full <= 1'b0;
      end else begin
         almost_full <= (count >= (AW+1)'(AF_LEVEL));
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed self-checking bench for uart_tx_feeder (default build, DEPTH=16).
module tb_uart_tx_feeder;

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_done;

   int checks = 0;
   int errors = 0;

   uart_tx_feeder #(
      .DEPTH (16),
      .DATA_W(8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (full),
      .empty   (empty),
      .count   (count),
      .overflow(overflow),
      .tx_data (tx_data),
      .tx_start(tx_start),
      .tx_done (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_start(input string tag);
      int n = 0;
      while (tx_start !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check({tag, "_launch"}, {31'd0, tx_start}, 32'd1);
   endtask

   // uart_tx stand-in: 40-cycle frame, then tx_done high for 3 cycles
   task automatic serve(input logic [7:0] exp, input string tag);
      bit ok;
      wait_start(tag);
      check({tag, "_data"}, {24'd0, tx_data}, {24'd0, exp});
      ok = 1'b1;
      repeat (40) begin
         tick();
         if (tx_start !== 1'b1 || tx_data !== exp) ok = 1'b0;
      end
      check({tag, "_held"}, {31'd0, ok}, 32'd1);
      tx_done = 1'b1;
      tick();
      check({tag, "_drop"}, {31'd0, tx_start}, 32'd0);
      ok = 1'b1;
      repeat (2) begin
         tick();
         if (tx_start !== 1'b0) ok = 1'b0;
      end
      check({tag, "_no_relaunch"}, {31'd0, ok}, 32'd1);
      tx_done = 1'b0;
      tick();
      check({tag, "_gap"}, {31'd0, tx_start}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst     = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      tx_done = 1'b0;
      tick();

      // 1: reset state and single-byte latency
      do_reset();
      check("rst_count", {27'd0, count}, 32'd0);
      check("rst_empty", {31'd0, empty}, 32'd1);
      check("rst_full", {31'd0, full}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_tx_start", {31'd0, tx_start}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      push(8'h81);
      check("t1_count_n1", {27'd0, count}, 32'd1);
      check("t1_start_n1", {31'd0, tx_start}, 32'd0);
      tick();
      check("t1_start_n2", {31'd0, tx_start}, 32'd1);
      check("t1_data_n2", {24'd0, tx_data}, 32'h81);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("t1_start_drop", {31'd0, tx_start}, 32'd0);
      check("t1_count_pop", {27'd0, count}, 32'd0);
      check("t1_empty_pop", {31'd0, empty}, 32'd1);
      repeat (3) tick();

      // 2: three back-to-back bytes against a long-frame uart_tx
      push(8'h11);
      push(8'h22);
      push(8'h33);
      serve(8'h11, "t2_b0");
      serve(8'h22, "t2_b1");
      serve(8'h33, "t2_b2");
      repeat (5) tick();
      check("t2_idle_start", {31'd0, tx_start}, 32'd0);
      check("t2_idle_count", {27'd0, count}, 32'd0);

      // 3: fill to DEPTH, overflow on 17th, refill after one completion
      do_reset();
      for (int i = 0; i < 16; i++) push(8'(8'hA0 + i));
      check("t3_full", {31'd0, full}, 32'd1);
      check("t3_count16", {27'd0, count}, 32'd16);
      check("t3_no_ovf", {31'd0, overflow}, 32'd0);
      push(8'hEE);
      check("t3_ovf_set", {31'd0, overflow}, 32'd1);
      check("t3_count_drop", {27'd0, count}, 32'd16);
      check("t3_head", {24'd0, tx_data}, 32'hA0);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("t3_count_pop", {27'd0, count}, 32'd15);
      check("t3_not_full", {31'd0, full}, 32'd0);
      push(8'h55);
      check("t3_refill_count", {27'd0, count}, 32'd16);
      check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
      tick();
      check("t3_next_launch", {31'd0, tx_start}, 32'd1);
      check("t3_next_data", {24'd0, tx_data}, 32'hA1);

      // 4: full + write + pop same cycle, then count=5 + write + pop
      wr_en   = 1'b1;
      wr_data = 8'h77;
      tx_done = 1'b1;
      tick();
      wr_en   = 1'b0;
      tx_done = 1'b0;
      check("t4_full_wr_pop_count", {27'd0, count}, 32'd15);
      check("t4_full_wr_pop_start", {31'd0, tx_start}, 32'd0);
      do_reset();
      for (int i = 1; i <= 5; i++) push(8'(i));
      check("t4_count5", {27'd0, count}, 32'd5);
      check("t4_busy_data", {24'd0, tx_data}, 32'h01);
      wr_en   = 1'b1;
      wr_data = 8'h06;
      tx_done = 1'b1;
      tick();
      wr_en   = 1'b0;
      tx_done = 1'b0;
      check("t4_wr_pop_count", {27'd0, count}, 32'd5);
      check("t4_wr_pop_start", {31'd0, tx_start}, 32'd0);
      repeat (2) tick();

      // 5: reset mid-frame with overflow set, then stale tx_done level
      do_reset();
      for (int i = 0; i < 17; i++) push(8'(i));
      check("t5_pre_ovf", {31'd0, overflow}, 32'd1);
      check("t5_pre_busy", {31'd0, tx_start}, 32'd1);
      do_reset();
      check("t5_rst_start", {31'd0, tx_start}, 32'd0);
      check("t5_rst_count", {27'd0, count}, 32'd0);
      check("t5_rst_ovf", {31'd0, overflow}, 32'd0);
      check("t5_rst_empty", {31'd0, empty}, 32'd1);
      wr_en   = 1'b1;
      wr_data = 8'h99;
      tx_done = 1'b1;
      tick();
      wr_en   = 1'b0;
      repeat (2) tick();
      check("t5_no_pop_count", {27'd0, count}, 32'd1);
      check("t5_no_pop_start", {31'd0, tx_start}, 32'd1);
      check("t5_no_pop_data", {24'd0, tx_data}, 32'h99);
      tx_done = 1'b0;
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("t5_pop_count", {27'd0, count}, 32'd0);
      check("t5_pop_start", {31'd0, tx_start}, 32'd0);
      repeat (2) tick();

      // 6: 40 bytes through a 16-entry FIFO, pointers wrap twice
      for (int i = 0; i < 8; i++) push(8'(i));
      for (int i = 0; i < 40; i++) begin
         if (i + 8 < 40) push(8'(i + 8));
         wait_start("t6");
         check("t6_data", {24'd0, tx_data}, i);
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
         tick();
      end
      repeat (3) tick();
      check("t6_final_count", {27'd0, count}, 32'd0);
      check("t6_final_empty", {31'd0, empty}, 32'd1);
      check("t6_final_start", {31'd0, tx_start}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
